// File: rtl/mem_wb_ctrl.sv
// mem_wb_ctrl: MEM stage controller sitting behind the EX/MEM register.
//   - Drives the data-memory request/ready handshake for loads and stores,
//     stalling EX/MEM and earlier stages while an access is outstanding.
//   - Resolves jump/branch redirects and raises precise exceptions
//     (undefined, overflow, bus timeout, optional misaligned access).
//   - Registers the retiring instruction into the MEM/WB stage.
// Configuration macro: ALIGN_CHECK_EN enables the word-alignment fault
// (cause 4); without it, address bits [1:0] pass straight to dm_addr.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   MEM_*, Jump_Addr,
//   PC_Branch                MEM-stage bundle from the EX/MEM register
//   dm_req/we/addr/wdata     data-memory request side
//   dm_rdata, dm_ready       data-memory response side
//   stall, flush             pipeline hold / squash of younger instructions
//   pc_redirect, redirect_pc PC load request and target
//   WB_*                     registered MEM/WB stage contents
//   exc_valid/cause/pc       registered one-cycle exception report
module mem_wb_ctrl #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       MEM_PC,
  input  logic [25:0]       Jump_Addr,
  input  logic [31:0]       PC_Branch,
  input  logic [31:0]       MEM_AluOut,
  input  logic [DATA_W-1:0] MEM_ReadData2,
  input  logic [4:0]        MEM_mux_RegDst_out,
  input  logic              MEM_Branch,
  input  logic              MEM_MemtoReg,
  input  logic              MEM_MemWrite,
  input  logic              MEM_RegWrite,
  input  logic              MEM_Jump,
  input  logic              MEM_zero,
  input  logic              MEM_undefine,
  input  logic              MEM_overflow,
  output logic              dm_req,
  output logic              dm_we,
  output logic [31:0]       dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ready,
  output logic              stall,
  output logic              flush,
  output logic              pc_redirect,
  output logic [31:0]       redirect_pc,
  output logic              WB_RegWrite,
  output logic              WB_MemtoReg,
  output logic [31:0]       WB_AluOut,
  output logic [DATA_W-1:0] WB_ReadData,
  output logic [4:0]        WB_RegDst,
  output logic [31:0]       WB_PC,
  output logic              exc_valid,
  output logic [2:0]        exc_cause,
  output logic [31:0]       exc_pc
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state;
  logic [7:0] wait_cnt;

  logic       access;
  logic       misalign;
  logic       fault;
  logic       timeout;
  logic       complete;
  logic       exc_any;
  logic       take_redirect;
  logic [2:0] cause;

  assign access = MEM_MemtoReg | MEM_MemWrite;

`ifdef ALIGN_CHECK_EN
  assign misalign = access & (|MEM_AluOut[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign fault = MEM_undefine | MEM_overflow | misalign;

  // Ready in the last WAIT cycle still wins over the timeout.
  assign timeout = (state == S_WAIT) && !dm_ready && (wait_cnt == MAX_CNT);

  always_comb begin
    dm_req        = 1'b0;
    stall         = 1'b0;
    complete      = 1'b0;
    exc_any       = 1'b0;
    take_redirect = 1'b0;
    cause         = 3'd0;
    dm_we         = 1'b0;
    dm_addr       = '0;
    dm_wdata      = '0;
    flush         = 1'b0;
    pc_redirect   = 1'b0;
    redirect_pc   = '0;
    if (!rst) begin
      if (state == S_IDLE) begin
        // A faulting access never reaches memory.
        dm_req   = access & ~fault;
        complete = ~dm_req | dm_ready;
        stall    = dm_req & ~dm_ready;
      end else begin
        dm_req   = ~timeout;
        complete = dm_ready | timeout;
        stall    = ~complete;
      end

      if (MEM_undefine)      cause = 3'd1;
      else if (MEM_overflow) cause = 3'd2;
      else if (misalign)     cause = 3'd4;
      else if (timeout)      cause = 3'd3;

      exc_any       = complete & (fault | timeout);
      take_redirect = complete & ~exc_any & (MEM_Jump | (MEM_Branch & MEM_zero));

      dm_we       = dm_req & MEM_MemWrite;
      dm_addr     = MEM_AluOut;
      dm_wdata    = MEM_ReadData2;
      flush       = exc_any | take_redirect;
      pc_redirect = take_redirect;
      if (take_redirect)
        redirect_pc = MEM_Jump ? {MEM_PC[31:28], Jump_Addr, 2'b00} : PC_Branch;
    end
  end

  // MEM -> WB stage boundary: FSM, write-back registers and exception report.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= 8'd0;
      WB_RegWrite <= 1'b0;
      WB_MemtoReg <= 1'b0;
      WB_AluOut   <= '0;
      WB_ReadData <= '0;
      WB_RegDst   <= '0;
      WB_PC       <= '0;
      exc_valid   <= 1'b0;
      exc_cause   <= 3'd0;
      exc_pc      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dm_req && !dm_ready) begin
            state    <= S_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        S_WAIT: begin
          if (complete) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= 8'd0;
        end
      endcase

      if (complete) begin
        WB_RegWrite <= MEM_RegWrite & ~exc_any;
        WB_MemtoReg <= MEM_MemtoReg;
        WB_AluOut   <= MEM_AluOut;
        WB_RegDst   <= MEM_mux_RegDst_out;
        WB_PC       <= MEM_PC;
      end else begin
        // Stalled cycles inject a bubble into WB.
        WB_RegWrite <= 1'b0;
        WB_MemtoReg <= 1'b0;
      end

      // Load data is captured only when a load actually handshakes.
      if (dm_req && dm_ready && MEM_MemtoReg)
        WB_ReadData <= dm_rdata;

      exc_valid <= exc_any;
      exc_cause <= exc_any ? cause : 3'd0;
      exc_pc    <= exc_any ? MEM_PC : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Directed testbench for mem_wb_ctrl (default parameters).
module tb_mem_wb_ctrl;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       MEM_PC;
  logic [25:0]       Jump_Addr;
  logic [31:0]       PC_Branch;
  logic [31:0]       MEM_AluOut;
  logic [DATA_W-1:0] MEM_ReadData2;
  logic [4:0]        MEM_mux_RegDst_out;
  logic              MEM_Branch, MEM_MemtoReg, MEM_MemWrite, MEM_RegWrite, MEM_Jump;
  logic              MEM_zero, MEM_undefine, MEM_overflow;
  logic              dm_req, dm_we;
  logic [31:0]       dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              stall, flush, pc_redirect;
  logic [31:0]       redirect_pc;
  logic              WB_RegWrite, WB_MemtoReg;
  logic [31:0]       WB_AluOut;
  logic [DATA_W-1:0] WB_ReadData;
  logic [4:0]        WB_RegDst;
  logic [31:0]       WB_PC;
  logic              exc_valid;
  logic [2:0]        exc_cause;
  logic [31:0]       exc_pc;

  int checks = 0;
  int errors = 0;

  mem_wb_ctrl #(.DATA_W(DATA_W), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .MEM_PC(MEM_PC), .Jump_Addr(Jump_Addr), .PC_Branch(PC_Branch),
    .MEM_AluOut(MEM_AluOut), .MEM_ReadData2(MEM_ReadData2),
    .MEM_mux_RegDst_out(MEM_mux_RegDst_out),
    .MEM_Branch(MEM_Branch), .MEM_MemtoReg(MEM_MemtoReg), .MEM_MemWrite(MEM_MemWrite),
    .MEM_RegWrite(MEM_RegWrite), .MEM_Jump(MEM_Jump),
    .MEM_zero(MEM_zero), .MEM_undefine(MEM_undefine), .MEM_overflow(MEM_overflow),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .stall(stall), .flush(flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg), .WB_AluOut(WB_AluOut),
    .WB_ReadData(WB_ReadData), .WB_RegDst(WB_RegDst), .WB_PC(WB_PC),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble;
    MEM_PC = '0; Jump_Addr = '0; PC_Branch = '0; MEM_AluOut = '0;
    MEM_ReadData2 = '0; MEM_mux_RegDst_out = '0;
    MEM_Branch = 0; MEM_MemtoReg = 0; MEM_MemWrite = 0; MEM_RegWrite = 0; MEM_Jump = 0;
    MEM_zero = 0; MEM_undefine = 0; MEM_overflow = 0;
    dm_ready = 0; dm_rdata = '0;
  endtask

  initial begin
    int  reqs;
    bit  done;

    // Reset with a pending load on the inputs: outputs must stay low.
    bubble();
    rst = 1;
    MEM_MemtoReg = 1;
    tick(); tick();
    @(negedge clk);
    check("rst_dm_req", dm_req, 0);
    check("rst_stall", stall, 0);
    check("rst_wb_regwrite", WB_RegWrite, 0);
    check("rst_wb_pc", WB_PC, 0);
    check("rst_exc_valid", exc_valid, 0);
    tick();
    rst = 0;
    bubble();

    // Load at 0x100, three stalled cycles then ready.
    tick();
    MEM_MemtoReg = 1; MEM_RegWrite = 1; MEM_AluOut = 32'h100;
    MEM_mux_RegDst_out = 5'd5; MEM_PC = 32'h1004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ld_req", dm_req, 1);
      check("ld_stall", stall, 1);
      check("ld_addr", dm_addr, 32'h100);
      check("ld_we", dm_we, 0);
      tick();
      check("ld_wb_bubble", WB_RegWrite, 0);
    end
    dm_ready = 1; dm_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("ld_done_req", dm_req, 1);
    check("ld_done_stall", stall, 0);
    tick();
    bubble();
    check("ld_wb_rdata", WB_ReadData, 32'hDEADBEEF);
    check("ld_wb_memtoreg", WB_MemtoReg, 1);
    check("ld_wb_regwrite", WB_RegWrite, 1);
    check("ld_wb_regdst", WB_RegDst, 5);
    check("ld_wb_pc", WB_PC, 32'h1004);

    // Zero-wait store.
    MEM_MemWrite = 1; MEM_AluOut = 32'h200; MEM_ReadData2 = 32'hCAFEF00D;
    dm_ready = 1; dm_rdata = 32'h11111111;
    @(negedge clk);
    check("st_req", dm_req, 1);
    check("st_we", dm_we, 1);
    check("st_wdata", dm_wdata, 32'hCAFEF00D);
    check("st_stall", stall, 0);
    tick();
    bubble();
    check("st_wb_regwrite", WB_RegWrite, 0);
    check("st_wb_rdata_hold", WB_ReadData, 32'hDEADBEEF);
    check("st_wb_aluout", WB_AluOut, 32'h200);

    // Taken branch.
    MEM_Branch = 1; MEM_zero = 1; PC_Branch = 32'h40;
    @(negedge clk);
    check("br_redirect", pc_redirect, 1);
    check("br_pc", redirect_pc, 32'h40);
    check("br_flush", flush, 1);
    tick();
    bubble();
    @(negedge clk);
    check("br_flush_once", flush, 0);
    check("br_redirect_once", pc_redirect, 0);

    // Jump, with a taken branch also present: jump wins.
    tick();
    MEM_Jump = 1; MEM_PC = 32'h10000008; Jump_Addr = 26'h0000010;
    MEM_Branch = 1; MEM_zero = 1; PC_Branch = 32'h40;
    @(negedge clk);
    check("jmp_redirect", pc_redirect, 1);
    check("jmp_pc", redirect_pc, 32'h10000040);
    check("jmp_flush", flush, 1);
    tick();
    bubble();

    // Load that never completes: bus timeout after 15 request cycles.
    MEM_MemtoReg = 1; MEM_RegWrite = 1; MEM_AluOut = 32'h400; MEM_PC = 32'h2000;
    reqs = 0;
    done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (dm_req) reqs++;
      if (!stall) done = 1;
      else tick();
    end
    check("to_done", done, 1);
    check("to_req_cycles", reqs, 15);
    check("to_req_low", dm_req, 0);
    check("to_flush", flush, 1);
    check("to_redirect", pc_redirect, 0);
    tick();
    bubble();
    check("to_exc_valid", exc_valid, 1);
    check("to_exc_cause", exc_cause, 3);
    check("to_exc_pc", exc_pc, 32'h2000);
    check("to_wb_regwrite", WB_RegWrite, 0);
    @(negedge clk);
    check("to_stall_released", stall, 0);
    tick();
    check("to_exc_pulse", exc_valid, 0);

    // Overflowing store alongside a taken branch: exception wins.
    MEM_MemWrite = 1; MEM_RegWrite = 1; MEM_overflow = 1;
    MEM_Branch = 1; MEM_zero = 1; PC_Branch = 32'h80; MEM_PC = 32'h300;
    dm_ready = 1;
    @(negedge clk);
    check("ov_req", dm_req, 0);
    check("ov_we", dm_we, 0);
    check("ov_flush", flush, 1);
    check("ov_redirect", pc_redirect, 0);
    check("ov_stall", stall, 0);
    tick();
    bubble();
    check("ov_exc_valid", exc_valid, 1);
    check("ov_exc_cause", exc_cause, 2);
    check("ov_exc_pc", exc_pc, 32'h300);
    check("ov_wb_regwrite", WB_RegWrite, 0);

    // Undefined outranks overflow.
    MEM_RegWrite = 1; MEM_undefine = 1; MEM_overflow = 1; MEM_PC = 32'h600;
    @(negedge clk);
    check("ud_flush", flush, 1);
    tick();
    bubble();
    check("ud_exc_cause", exc_cause, 1);
    check("ud_exc_pc", exc_pc, 32'h600);

    // Misaligned load at 0x102.
    MEM_MemtoReg = 1; MEM_RegWrite = 1; MEM_AluOut = 32'h102; MEM_PC = 32'h700;
    dm_ready = 1; dm_rdata = 32'h22222222;
    @(negedge clk);
`ifdef ALIGN_CHECK_EN
    check("mis_req", dm_req, 0);
    check("mis_flush", flush, 1);
    tick();
    bubble();
    check("mis_exc_valid", exc_valid, 1);
    check("mis_exc_cause", exc_cause, 4);
    check("mis_wb_regwrite", WB_RegWrite, 0);
`else
    check("mis_req", dm_req, 1);
    check("mis_addr", dm_addr, 32'h102);
    check("mis_flush", flush, 0);
    tick();
    bubble();
    check("mis_exc_valid", exc_valid, 0);
    check("mis_wb_rdata", WB_ReadData, 32'h22222222);
`endif

    // Reset while waiting on memory.
    MEM_MemtoReg = 1; MEM_RegWrite = 1; MEM_AluOut = 32'h500; MEM_PC = 32'h800;
    @(negedge clk);
    check("rw_stall_pre", stall, 1);
    tick();
    rst = 1;
    #1;
    check("rw_req_drop", dm_req, 0);
    check("rw_stall_drop", stall, 0);
    check("rw_flush", flush, 0);
    tick();
    check("rw_wb_regwrite", WB_RegWrite, 0);
    check("rw_wb_rdata", WB_ReadData, 0);
    check("rw_wb_aluout", WB_AluOut, 0);
    check("rw_exc_valid", exc_valid, 0);
    rst = 0;
    dm_ready = 1; dm_rdata = 32'h33333333;
    @(negedge clk);
    check("rw_idle_req", dm_req, 1);
    check("rw_idle_stall", stall, 0);
    tick();
    bubble();
    check("rw_after_rdata", WB_ReadData, 32'h33333333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_ctrl.md
Name: mem_wb_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register: takes the MEM-stage bundle and drives the data-memory request/ready handshake.
- Resolves branch/jump redirect and raises precise exceptions.
- Registers the result into the MEM/WB stage for write-back.
- Asserts stall back to the EX/MEM register and earlier stages while a data access is outstanding.

Parameters:
- DATA_W, 32, datapath and memory data width
- MAX_WAIT, 15, cycles in WAIT before bus timeout (1..255)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- MEM_PC  in  32  PC carried with the instruction (PC+4 value)
- Jump_Addr  in  26  instr_index field of the jump
- PC_Branch  in  32  precomputed branch target
- MEM_AluOut  in  32  ALU result / memory byte address
- MEM_ReadData2  in  DATA_W  store data
- MEM_mux_RegDst_out  in  5  destination register
- MEM_Branch, MEM_MemtoReg, MEM_MemWrite, MEM_RegWrite, MEM_Jump  in  1 each  control bits
- MEM_zero, MEM_undefine, MEM_overflow  in  1 each  ALU/decoder status
- dm_req  out  1  memory request
- dm_we  out  1  1 = store
- dm_addr  out  32  = MEM_AluOut
- dm_wdata  out  DATA_W  = MEM_ReadData2
- dm_rdata  in  DATA_W  load data, valid with dm_ready
- dm_ready  in  1  access completes this cycle
- stall  out  1  hold EX/MEM and earlier stages
- flush  out  1  squash younger instructions (IF/ID/EX)
- pc_redirect  out  1  load redirect_pc into PC
- redirect_pc  out  32  new PC
- WB_RegWrite, WB_MemtoReg  out  1 each  registered controls
- WB_AluOut, WB_ReadData  out  32/DATA_W  registered data
- WB_RegDst  out  5  registered destination register
- WB_PC  out  32  registered PC
- exc_valid  out  1  one-cycle exception pulse
- exc_cause  out  3  cause: 0 none, 1 undefined, 2 overflow, 3 bus timeout, 4 misaligned
- exc_pc  out  32  MEM_PC of the faulting instruction

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, wait counter=0.
  - All WB_* outputs, exc_valid, exc_cause and exc_pc = 0.
  - Combinational outputs are forced low while rst=1.
- Definitions:
  - access = MEM_MemtoReg | MEM_MemWrite.
  - fault = MEM_undefine | MEM_overflow.
  - Bubble = all control bits 0; a bubble produces no side effects.
- FSM states: IDLE, WAIT.
  - IDLE: if access & !fault, dm_req=1 combinationally.
    - dm_ready=1 in the same cycle: zero-wait completion, no stall, stay in IDLE.
    - Otherwise: stall=1, go to WAIT, counter=1.
  - WAIT: dm_req=1 and stall=1; dm_addr, dm_we and dm_wdata are held stable (inputs are frozen by stall).
    - dm_ready=1: complete, stall=0 that cycle, go to IDLE.
    - Else if counter==MAX_WAIT: timeout, dm_req=0, go to IDLE, raise cause 3.
    - Else counter+1.
- Completion cycle:
  - The instruction retires in the cycle it completes. That is the IDLE cycle with no access, a zero-wait access, or the WAIT cycle with ready or timeout.
  - On the next rising edge, WB_* load MEM_* / dm_rdata.
  - WB_ReadData loads only on a load; otherwise it holds.
- Non-completing cycles: WB_RegWrite=0 and WB_MemtoReg=0 (bubble into WB).
- Redirect, asserted combinationally in the completion cycle, only when no exception:
  - Jump: redirect_pc = {MEM_PC[31:28], Jump_Addr, 2'b00}.
  - Else if MEM_Branch & MEM_zero: redirect_pc = PC_Branch.
  - In both cases pc_redirect=1 and flush=1 for exactly that cycle.
  - Jump has priority over branch.
- Exceptions:
  - Priority: undefined > overflow > misaligned > timeout.
  - fault suppresses the memory request entirely; no store reaches memory.
  - In the completion cycle:
    - flush=1, pc_redirect=0.
    - WB_RegWrite is loaded as 0.
    - exc_valid pulses one cycle after, with exc_cause and exc_pc registered.
- Simultaneous redirect and exception: the exception wins; no redirect.
- rst during WAIT: FSM returns to IDLE, dm_req drops immediately, no WB write and no exception.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- When defined, an access with MEM_AluOut[1:0]!=0 is treated as fault cause 4:
  - no dm_req is issued
  - completes in IDLE with flush=1 and WB_RegWrite=0
  - exc_valid pulses next cycle with exc_cause=4.
- When undefined, there is no alignment check and address bits [1:0] pass through to dm_addr unchanged.

Test Plan:
- Load, AluOut=0x100, dm_ready held low 3 cycles then high with rdata=0xDEADBEEF -> stall high 3 cycles, one dm_req per cycle with addr stable; next edge WB_ReadData=0xDEADBEEF, WB_MemtoReg=1, WB_RegWrite=1.
- Store with dm_ready=1 in the same cycle -> dm_we=1, dm_wdata=MEM_ReadData2, no stall, WB_RegWrite=0.
- Branch=1, zero=1, PC_Branch=0x40 -> pc_redirect=1, redirect_pc=0x40, flush one cycle. Jump with MEM_PC=0x10000008, Jump_Addr=0x0000010 -> redirect_pc=0x10000040.
- Load with dm_ready never high, MAX_WAIT=15 -> dm_req for 15 cycles then low; exc_valid pulse with cause 3; WB_RegWrite=0; stall released.
- Store with MEM_overflow=1 and MEM_Branch=MEM_zero=1 -> no dm_req, flush=1, pc_redirect=0, exc_cause=2, exc_pc=MEM_PC.
- With ALIGN_CHECK_EN: load at 0x102 -> no dm_req, exc_cause=4. Without the macro: dm_addr=0x102 is issued. Also assert rst mid-WAIT -> dm_req low in the same cycle, all outputs return to 0.
